// File: rtl/ram_sp_ctrl.sv
// ram_sp_ctrl: single-port synchronous RAM with byte-lane write enables,
// a cs/ready request handshake, a 1- or 2-cycle registered read pipeline
// and a tri-state gated output. After reset, a clear sequencer zeroes every
// word before requests are accepted.
//
// Optional feature: define RAM_PARITY_EN to store one even-parity bit per
// byte lane and flag lane mismatches on reads (perr). Without it perr is 0.
//
// Handshake: a request (cs, w, add, i, be) is accepted on a rising edge of c
// where cs && ready. ready is 1 only in RUN; cs while ready=0 is ignored.
// Reads produce a one-cycle o_valid pulse RD_LAT cycles after acceptance,
// in issue order; writes produce no o_valid.

module ram_sp_ctrl #(
  parameter int DW     = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int RD_LAT = 1
) (
  input  logic            c,
  input  logic            rst_n,
  input  logic            cs,
  input  logic            w,
  input  logic [AW-1:0]   add,
  input  logic [DW-1:0]   i,
  input  logic [DW/8-1:0] be,
  input  logic            oe,
  output logic [DW-1:0]   o,
  output logic            o_valid,
  output logic            ready,
  output logic            aerr,
  output logic            perr
);

  localparam int            NB      = DW / 8;
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_ptr_q, clr_ptr_d;

  logic [DW-1:0]   mem_q [DEPTH];
`ifdef RAM_PARITY_EN
  logic [NB-1:0]   par_q [DEPTH];
`endif

  logic            accept, wr_acc, rd_acc, in_range;
  logic [DW-1:0]   rd_word;
  logic            rd_perr;

  logic            v1_q, perr1_q, aerr_q;
  logic [DW-1:0]   data1_q;
  logic [DW-1:0]   data_out;
  logic            valid_out, perr_out;

  assign ready    = (state_q == ST_RUN);
  assign accept   = cs && ready;
  assign wr_acc   = accept && w;
  assign rd_acc   = accept && !w;
  assign in_range = ({1'b0, add} < DEPTH_W);

  // State register and clear pointer; reset restarts the clear sequence
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state: INIT walks clr_ptr over every word, then RUN until reset
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_INIT: begin
        if (clr_ptr_q == LAST) begin
          state_d   = ST_RUN;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d   = ST_INIT;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Storage: INIT zeroes one word per cycle; RUN applies byte-enabled writes
  always_ff @(posedge c) begin
    if (state_q == ST_INIT) begin
      mem_q[clr_ptr_q] <= '0;
`ifdef RAM_PARITY_EN
      par_q[clr_ptr_q] <= '0;
`endif
    end else if (wr_acc && in_range) begin
      for (int k = 0; k < NB; k++) begin
        if (be[k]) begin
          mem_q[add][8*k +: 8] <= i[8*k +: 8];
`ifdef RAM_PARITY_EN
          par_q[add][k] <= ^i[8*k +: 8];
`endif
        end
      end
    end
  end

  // Read word lookup; out-of-range addresses read as zero with no parity error
  always_comb begin
    rd_word = '0;
    rd_perr = 1'b0;
    if (in_range) begin
      rd_word = mem_q[add];
`ifdef RAM_PARITY_EN
      for (int k = 0; k < NB; k++) begin
        if (par_q[add][k] != ^mem_q[add][8*k +: 8]) begin
          rd_perr = 1'b1;
        end
      end
`endif
    end
  end

  // First read stage: data register loads only on an accepted read
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      data1_q <= '0;
      perr1_q <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      v1_q    <= rd_acc;
      perr1_q <= rd_acc && rd_perr;
      aerr_q  <= accept && !in_range;
      if (rd_acc) begin
        data1_q <= rd_word;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          v2_q, perr2_q;
      logic [DW-1:0] data2_q;

      // Extra output stage; holds its data until the next read arrives
      always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
          v2_q    <= 1'b0;
          data2_q <= '0;
          perr2_q <= 1'b0;
        end else begin
          v2_q    <= v1_q;
          perr2_q <= perr1_q;
          if (v1_q) begin
            data2_q <= data1_q;
          end
        end
      end

      assign data_out  = data2_q;
      assign valid_out = v2_q;
      assign perr_out  = perr2_q;
    end else begin : g_lat1
      assign data_out  = data1_q;
      assign valid_out = v1_q;
      assign perr_out  = perr1_q;
    end
  endgenerate

  assign o       = oe ? data_out : {DW{1'bz}};
  assign o_valid = valid_out;
  assign aerr    = aerr_q;
`ifdef RAM_PARITY_EN
  assign perr    = perr_out;
`else
  assign perr    = 1'b0;
`endif

endmodule
